crossbar_sched: RTL and testbench



---
 rtl/crossbar_sched.sv | 199 +++++++++++++++++++
 tb/tb_crossbar_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_sched.sv
// Crossbar route scheduler: two route banks driven onto the crossbar selects, with manual or
// dwell-timed bank switching and a blanking interval. Define CROSSBAR_SCHED_IRQ_EN for bank_irq.
module crossbar_sched #(
    parameter logic [7:0]  ADDR_HI      = 8'h04,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter logic [15:0] DWELL_RESET  = 16'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic [23:0] route,
    output logic [7:0]  out_enable,
    output logic        bank_irq
);

    typedef enum logic [1:0] {StOff, StBlank, StHold} state_e;

    localparam logic [3:0] BlankLast = 4'(BLANK_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q;
    logic [23:0] bank0_q, bank1_q;
    logic [15:0] dwell_q;
    logic [15:0] dwell_cnt_q, dwell_cnt_d;
    logic [3:0]  blank_cnt_q, blank_cnt_d;
    logic        active_q, active_d;
    logic        target_q, target_d;
    logic [23:0] route_q, route_d;
    logic        enter_blank;
    logic        irq_pending;
    logic [31:0] rdata_d;

    logic       access, wr_en;
    logic [7:0] offset;
    logic       enable, auto_mode, sel, commit, expire;
    logic       unused_bits;

    assign access = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_HI);
    assign wr_en  = access && (iomem_wstrb != 4'b0000);
    assign offset = iomem_addr[7:0];

    assign enable    = ctrl_q[0];
    assign auto_mode = ctrl_q[1];
    assign sel       = ctrl_q[2];
    assign commit    = ctrl_q[3];
    // >= so a DWELL shrunk below the running count still forces a toggle
    assign expire    = (dwell_q != 16'd0) && (dwell_cnt_q >= dwell_q - 16'd1);

    assign unused_bits = ^{iomem_addr[23:8], iomem_wdata[31:24]};

    // Register file and bus handshake
    always_comb begin
        rdata_d = 32'd0;
        case (offset)
            8'h00:   rdata_d = {29'd0, ctrl_q[2:0]};
            8'h04:   rdata_d = {dwell_cnt_q, 13'd0, irq_pending, state_q == StBlank, active_q};
            8'h08:   rdata_d = {8'd0, bank0_q};
            8'h0C:   rdata_d = {8'd0, bank1_q};
            8'h10:   rdata_d = {16'd0, dwell_q};
            default: rdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'd0;
            ctrl_q      <= 4'd0;
            bank0_q     <= 24'd0;
            bank1_q     <= 24'd0;
            dwell_q     <= DWELL_RESET;
        end else begin
            iomem_ready <= access;
            iomem_rdata <= access ? rdata_d : 32'd0;
            ctrl_q[3]   <= 1'b0;
            if (wr_en && offset == 8'h00 && iomem_wstrb[0]) begin
                ctrl_q <= iomem_wdata[3:0];
            end
            for (int b = 0; b < 3; b++) begin
                if (wr_en && offset == 8'h08 && iomem_wstrb[b]) begin
                    bank0_q[8*b +: 8] <= iomem_wdata[8*b +: 8];
                end
                if (wr_en && offset == 8'h0C && iomem_wstrb[b]) begin
                    bank1_q[8*b +: 8] <= iomem_wdata[8*b +: 8];
                end
            end
            for (int b = 0; b < 2; b++) begin
                if (wr_en && offset == 8'h10 && iomem_wstrb[b]) begin
                    dwell_q[8*b +: 8] <= iomem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Bank sequencing
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        active_d    = active_q;
        blank_cnt_d = blank_cnt_q;
        route_d     = route_q;
        enter_blank = 1'b0;
        case (state_q)
            StOff: begin
                if (enable) begin
                    enter_blank = 1'b1;
                    target_d    = auto_mode ? 1'b0 : sel;
                end
            end
            StBlank: begin
                if (!enable) begin
                    state_d = StOff;
                end else if (blank_cnt_q == BlankLast) begin
                    state_d  = StHold;
                    active_d = target_q;
                end else begin
                    blank_cnt_d = blank_cnt_q + 4'd1;
                end
            end
            StHold: begin
                if (!enable) begin
                    state_d = StOff;
                end else if (auto_mode && expire) begin
                    enter_blank = 1'b1;
                    target_d    = ~active_q;
                end else if (!auto_mode && (sel != active_q)) begin
                    enter_blank = 1'b1;
                    target_d    = sel;
                end else if (commit) begin
                    enter_blank = 1'b1;
                    target_d    = active_q;
                end
            end
            default: state_d = StOff;
        endcase
        if (enter_blank) begin
            state_d     = StBlank;
            blank_cnt_d = 4'd0;
            route_d     = target_d ? bank1_q : bank0_q;
        end
        dwell_cnt_d = (state_q == StHold && state_d == StHold) ? dwell_cnt_q + 16'd1 : 16'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StOff;
            target_q    <= 1'b0;
            active_q    <= 1'b0;
            blank_cnt_q <= 4'd0;
            dwell_cnt_q <= 16'd0;
            route_q     <= 24'd0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            active_q    <= active_d;
            blank_cnt_q <= blank_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            route_q     <= route_d;
        end
    end

    assign route      = route_q;
    // Gated by enable so clearing it blanks the outputs without waiting for OFF
    assign out_enable = (state_q == StHold && enable) ? 8'hFF : 8'h00;

`ifdef CROSSBAR_SCHED_IRQ_EN
    logic irq_q, pend_q;
    logic switch_done, status_wr;

    assign switch_done = (state_q == StBlank) && (state_d == StHold);
    assign status_wr   = wr_en && (offset == 8'h04);

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            irq_q <= switch_done;
            if (switch_done) begin
                pend_q <= 1'b1;
            end else if (status_wr) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign bank_irq    = irq_q;
    assign irq_pending = pend_q;
`else
    assign bank_irq    = 1'b0;
    assign irq_pending = 1'b0;
`endif

endmodule

// File: tb/tb_crossbar_sched.sv
// Randomized bench for crossbar_sched against a cycle-level behavioural model of the scheduler.
module tb_crossbar_sched;

    localparam int BLANK_N = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic [23:0] route;
    logic [7:0]  out_enable;
    logic        bank_irq;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    crossbar_sched #(
        .ADDR_HI(8'h04),
        .BLANK_CYCLES(BLANK_N),
        .DWELL_RESET(16'd1000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .route(route),
        .out_enable(out_enable),
        .bank_irq(bank_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_phase;       // 0 = off, 1 = blanking, 2 = holding
    int          m_blank_seen;  // blanking cycles elapsed, including the current one
    logic [15:0] m_hold_cnt;
    logic        m_active, m_target, m_ready, m_irq, m_pend;
    logic [3:0]  m_ctrl;
    logic [23:0] m_bank [2];
    logic [15:0] m_dwell;
    logic [23:0] m_route;
    logic [31:0] m_rdata;

    task automatic model_step();
        logic en, au, sl, cm, go, tgt, switched, access, wr, expire;
        logic [7:0]  off;
        logic [31:0] rd;
        int nphase;
        if (reset) begin
            m_phase = 0; m_blank_seen = 0; m_hold_cnt = 0; m_active = 0; m_target = 0;
            m_ready = 0; m_irq = 0; m_pend = 0; m_ctrl = 0; m_bank[0] = 0; m_bank[1] = 0;
            m_dwell = 16'd1000; m_route = 0; m_rdata = 0;
            return;
        end
        access = iomem_valid && !m_ready && (iomem_addr[31:24] == 8'h04);
        wr = access && (iomem_wstrb != 0);
        off = iomem_addr[7:0];
        rd = 0;
        case (off)
            8'h00: rd = {29'd0, m_ctrl[2:0]};
            8'h04: rd = {m_hold_cnt, 13'd0, m_pend, m_phase == 1, m_active};
            8'h08: rd = {8'd0, m_bank[0]};
            8'h0C: rd = {8'd0, m_bank[1]};
            8'h10: rd = {16'd0, m_dwell};
            default: rd = 0;
        endcase
        en = m_ctrl[0]; au = m_ctrl[1]; sl = m_ctrl[2]; cm = m_ctrl[3];
        go = 0; tgt = m_target; switched = 0; nphase = m_phase;
        expire = (m_dwell != 0) && (int'(m_hold_cnt) + 1 >= int'(m_dwell));
        case (m_phase)
            0: if (en) begin go = 1; tgt = au ? 1'b0 : sl; end
            1: begin
                if (!en) nphase = 0;
                else if (m_blank_seen == BLANK_N) begin nphase = 2; switched = 1; end
                else m_blank_seen++;
            end
            default: begin
                if (!en) nphase = 0;
                else if (au && expire) begin go = 1; tgt = !m_active; end
                else if (!au && sl != m_active) begin go = 1; tgt = sl; end
                else if (cm) begin go = 1; tgt = m_active; end
            end
        endcase
        if (switched) m_active = m_target;
        if (go) begin
            nphase = 1; m_blank_seen = 1; m_target = tgt; m_route = m_bank[tgt];
        end
        m_hold_cnt = (m_phase == 2 && nphase == 2) ? m_hold_cnt + 16'd1 : 16'd0;
        m_phase = nphase;
`ifdef CROSSBAR_SCHED_IRQ_EN
        m_irq = switched;
        if (switched) m_pend = 1;
        else if (wr && off == 8'h04) m_pend = 0;
`endif
        m_ready = access;
        m_rdata = access ? rd : 0;
        m_ctrl[3] = 0;
        if (wr && off == 8'h00 && iomem_wstrb[0]) m_ctrl = iomem_wdata[3:0];
        for (int b = 0; b < 3; b++) begin
            if (wr && off == 8'h08 && iomem_wstrb[b]) m_bank[0][8*b +: 8] = iomem_wdata[8*b +: 8];
            if (wr && off == 8'h0C && iomem_wstrb[b]) m_bank[1][8*b +: 8] = iomem_wdata[8*b +: 8];
        end
        for (int b = 0; b < 2; b++) begin
            if (wr && off == 8'h10 && iomem_wstrb[b]) m_dwell[8*b +: 8] = iomem_wdata[8*b +: 8];
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", {31'd0, iomem_ready}, {31'd0, m_ready});
            check("rdata", iomem_rdata, m_rdata);
            check("route", {8'd0, route}, {8'd0, m_route});
            check("out_enable", {24'd0, out_enable},
                  (m_phase == 2 && m_ctrl[0]) ? 32'hFF : 32'h0);
            check("bank_irq", {31'd0, bank_irq}, {31'd0, m_irq});
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; returns at the negedge where ready is seen, with valid dropped.
    task automatic bus(input logic [7:0] off, input logic [31:0] data, input logic [3:0] strb,
                       output logic [31:0] rd);
        int n = 0;
        iomem_valid = 1'b1;
        iomem_addr  = {8'h04, 16'($urandom), off};
        iomem_wdata = data;
        iomem_wstrb = strb;
        do begin
            @(negedge clk);
            n++;
        end while (!iomem_ready && n < 20);
        check("bus_timeout", {31'd0, iomem_ready}, 32'd1);
        rd = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] data);
        logic [31:0] rd;
        bus(off, data, 4'hF, rd);
    endtask

    task automatic rd_reg(input logic [7:0] off, output logic [31:0] rd);
        bus(off, 32'd0, 4'h0, rd);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  oe_seq [12];
        logic [23:0] rt_seq [12];
        logic [7:0]  offs [7];
        int n, op;
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20};
        reset = 1'b1; iomem_valid = 1'b0; iomem_wstrb = 0; iomem_addr = 0; iomem_wdata = 0;
        cycles(3);
        chk_en = 1'b1;
        reset = 1'b0;

        // Reset values
        check("rst_route", {8'd0, route}, 32'd0);
        check("rst_oe", {24'd0, out_enable}, 32'd0);
        rd_reg(8'h10, r); check("rst_dwell", r, 32'h000003E8);
        rd_reg(8'h04, r); check("rst_status", r, 32'h0);

        // Enable from OFF: one OFF cycle, two blank cycles, then outputs on
        wr(8'h08, 32'h000F_AC68);
        wr(8'h00, 32'h1);
        cycles(1); check("en_blank0", {24'd0, out_enable}, 32'h0);
        check("en_route", {8'd0, route}, 32'h0F_AC68);
        cycles(1); check("en_blank1", {24'd0, out_enable}, 32'h0);
        cycles(1); check("en_on", {24'd0, out_enable}, 32'hFF);

        // Manual switch to bank 1
        wr(8'h0C, 32'h0);
        wr(8'h00, 32'h5);
        cycles(1); check("sw_blank0", {24'd0, out_enable}, 32'h0);
        check("sw_route", {8'd0, route}, 32'h0);
        cycles(1); check("sw_blank1", {24'd0, out_enable}, 32'h0);
        cycles(1); check("sw_on", {24'd0, out_enable}, 32'hFF);
        rd_reg(8'h04, r); check("sw_status", {30'd0, r[1:0]}, 32'h1);

        // Auto mode with DWELL=4: 4 on, 2 blank per bank
        wr(8'h10, 32'd4);
        wr(8'h00, 32'h3);
        n = 0;
        while (out_enable != 8'h00 && n < 40) begin @(negedge clk); n++; end
        while (out_enable != 8'hFF && n < 40) begin @(negedge clk); n++; end
        check("auto_sync", {31'd0, n < 40}, 32'd1);
        for (int k = 0; k < 12; k++) begin
            oe_seq[k] = out_enable; rt_seq[k] = route;
            @(negedge clk);
        end
        for (int k = 0; k < 12; k++) begin
            check($sformatf("auto_oe%0d", k), {24'd0, oe_seq[k]},
                  (k % 6 < 4) ? 32'hFF : 32'h0);
        end
        check("auto_alt", {8'd0, rt_seq[0] ^ rt_seq[6]}, 32'h0F_AC68);
        check("auto_hold", {8'd0, rt_seq[3]}, {8'd0, rt_seq[0]});

        // Commit reloads an edited table on the same bank
        wr(8'h00, 32'h1);
        cycles(12);
        wr(8'h08, 32'h1);
        check("edit_route0", {8'd0, route}, 32'h0F_AC68);
        cycles(1); check("edit_route1", {8'd0, route}, 32'h0F_AC68);
        wr(8'h00, 32'h9);
        cycles(1); check("cm_blank0", {24'd0, out_enable}, 32'h0);
        check("cm_route", {8'd0, route}, 32'h1);
        cycles(1); check("cm_blank1", {24'd0, out_enable}, 32'h0);
        cycles(1); check("cm_on", {24'd0, out_enable}, 32'hFF);
        rd_reg(8'h04, r); check("cm_active", {31'd0, r[0]}, 32'h0);
        rd_reg(8'h00, r); check("cm_ctrl", r, 32'h1);

        // Disable mid-blank: OFF, outputs low, route held
        wr(8'h0C, 32'h12_3456);
        wr(8'h00, 32'h5);
        wr(8'h00, 32'h0);
        cycles(1); check("dis_oe", {24'd0, out_enable}, 32'h0);
        check("dis_route", {8'd0, route}, 32'h12_3456);
        rd_reg(8'h04, r); check("dis_status", {r[31:16], 14'd0, r[1:0]}, 32'h0);

        // Reset mid-blank
        wr(8'h00, 32'h1);
        cycles(1);
        reset = 1'b1;
        cycles(1);
        check("rr_route", {8'd0, route}, 32'h0);
        check("rr_oe", {24'd0, out_enable}, 32'h0);
        check("rr_ready", {31'd0, iomem_ready}, 32'h0);
        reset = 1'b0;
        rd_reg(8'h10, r); check("rr_dwell", r, 32'h000003E8);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 99);
            if (op < 20) begin
                r = $urandom;
                r[0] = ($urandom_range(0, 9) != 0);
                bus(8'h00, r, 4'($urandom_range(0, 15)) | 4'h1, r);
            end else if (op < 35) begin
                bus($urandom_range(0, 1) ? 8'h08 : 8'h0C, $urandom, 4'($urandom), r);
            end else if (op < 45) begin
                bus(8'h10, $urandom_range(0, 7), $urandom_range(0, 3) == 0 ? 4'hF : 4'h1, r);
            end else if (op < 65) begin
                rd_reg(offs[$urandom_range(0, 6)], r);
            end else if (op < 70) begin
                bus(8'h04, $urandom, 4'hF, r);
            end else if (op < 73) begin
                iomem_valid = 1'b1; iomem_wstrb = 4'hF;
                iomem_addr = {8'h05, 16'($urandom), 8'h08}; iomem_wdata = $urandom;
                cycles(2);
                iomem_valid = 1'b0; iomem_wstrb = 4'h0;
            end else if (op < 75) begin
                reset = 1'b1; cycles(1); reset = 1'b0;
            end else begin
                cycles($urandom_range(1, 8));
            end
        end
        cycles(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
